// File: rtl/morph_frame_ctrl.sv
// rtl/morph_frame_ctrl.sv - frame sequencer for a 4-line-buffer 3x3 erosion stage
// Steers pixel writes into a rotating line bank and issues row reads once three lines are held.
module morph_frame_ctrl #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic                       i_pixel_valid,
    output logic                       o_ready,
    output logic                       o_wr_en,
    output logic [1:0]                 o_wr_line_sel,
    output logic [$clog2(IMG_W)-1:0]   o_wr_addr,
    output logic                       o_rd_en,
    output logic [1:0]                 o_rd_line_sel,
    output logic [$clog2(IMG_W)-1:0]   o_rd_addr,
    output logic                       o_window_valid,
    output logic                       o_busy,
    output logic                       o_frame_done
);

    localparam int AW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);
    localparam logic [RW-1:0] IN_ROWS  = RW'(IMG_H);
    localparam logic [RW-1:0] OUT_ROWS = RW'(IMG_H - 2);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_col_q, wr_col_d;
    logic [1:0]    wr_line_q, wr_line_d;
    logic [RW-1:0] in_rows_q, in_rows_d;
    logic [2:0]    lines_q, lines_d;
    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] rd_col_q, rd_col_d;
    logic [1:0]    rd_line_q, rd_line_d;
    logic [RW-1:0] out_rows_q, out_rows_d;
    logic          win_valid_q, win_valid_d;

    logic ready;
    logic wr_en;
    logic wr_line_done;
    logic rd_line_done;
    logic last_window;

    always_comb begin
        ready        = (state_q == ST_RUN) && (lines_q != 3'd4);
        wr_en        = i_pixel_valid && ready;
        wr_line_done = wr_en && (wr_col_q == COL_LAST);
        rd_line_done = rd_en_q && (rd_col_q == COL_LAST);
        // The final window leaves the pipe in the gap cycle after the last read line.
        last_window  = (state_q == ST_DRAIN) && win_valid_q && !rd_en_q
                       && (out_rows_q == OUT_ROWS);
    end

    always_comb begin
        state_d     = state_q;
        wr_col_d    = wr_col_q;
        wr_line_d   = wr_line_q;
        in_rows_d   = in_rows_q;
        lines_d     = lines_q;
        rd_en_d     = rd_en_q;
        rd_col_d    = rd_col_q;
        rd_line_d   = rd_line_q;
        out_rows_d  = out_rows_q;
        win_valid_d = rd_en_q;

        if (wr_en) begin
            if (wr_line_done) begin
                wr_col_d  = '0;
                wr_line_d = wr_line_q + 2'd1;
                in_rows_d = in_rows_q + RW'(1);
            end else begin
                wr_col_d = wr_col_q + AW'(1);
            end
        end

        if (wr_line_done && !rd_line_done) begin
            lines_d = lines_q + 3'd1;
        end else if (!wr_line_done && rd_line_done) begin
            lines_d = lines_q - 3'd1;
        end

        // A line read always ends with rd_en low for at least one cycle.
        if (rd_en_q) begin
            if (rd_line_done) begin
                rd_en_d    = 1'b0;
                rd_col_d   = '0;
                rd_line_d  = rd_line_q + 2'd1;
                out_rows_d = out_rows_q + RW'(1);
            end else begin
                rd_col_d = rd_col_q + AW'(1);
            end
        end else begin
            rd_en_d = ((state_q == ST_RUN) || (state_q == ST_DRAIN))
                      && (lines_q >= 3'd3) && (out_rows_q < OUT_ROWS);
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (in_rows_d == IN_ROWS) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_window) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                // Leftover two lines are dropped and the bank pointers realigned for the next frame.
                state_d     = ST_IDLE;
                wr_col_d    = '0;
                wr_line_d   = 2'd0;
                in_rows_d   = '0;
                lines_d     = 3'd0;
                rd_en_d     = 1'b0;
                rd_col_d    = '0;
                rd_line_d   = 2'd0;
                out_rows_d  = '0;
                win_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            wr_col_q    <= '0;
            wr_line_q   <= 2'd0;
            in_rows_q   <= '0;
            lines_q     <= 3'd0;
            rd_en_q     <= 1'b0;
            rd_col_q    <= '0;
            rd_line_q   <= 2'd0;
            out_rows_q  <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_col_q    <= wr_col_d;
            wr_line_q   <= wr_line_d;
            in_rows_q   <= in_rows_d;
            lines_q     <= lines_d;
            rd_en_q     <= rd_en_d;
            rd_col_q    <= rd_col_d;
            rd_line_q   <= rd_line_d;
            out_rows_q  <= out_rows_d;
            win_valid_q <= win_valid_d;
        end
    end

    always_comb begin
        o_ready        = ready;
        o_wr_en        = wr_en;
        o_wr_line_sel  = wr_line_q;
        o_wr_addr      = wr_col_q;
        o_rd_en        = rd_en_q;
        o_rd_line_sel  = rd_line_q;
        o_rd_addr      = rd_col_q;
        o_window_valid = win_valid_q;
        o_busy         = (state_q != ST_IDLE);
        o_frame_done   = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// tb/tb_morph_frame_ctrl.sv - directed checks of morph_frame_ctrl at IMG_W=4, IMG_H=6
module tb_morph_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 6;
    localparam int AW = $clog2(W);

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic          i_pixel_valid;
    logic          o_ready;
    logic          o_wr_en;
    logic [1:0]    o_wr_line_sel;
    logic [AW-1:0] o_wr_addr;
    logic          o_rd_en;
    logic [1:0]    o_rd_line_sel;
    logic [AW-1:0] o_rd_addr;
    logic          o_window_valid;
    logic          o_busy;
    logic          o_frame_done;

    morph_frame_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_pixel_valid  (i_pixel_valid),
        .o_ready        (o_ready),
        .o_wr_en        (o_wr_en),
        .o_wr_line_sel  (o_wr_line_sel),
        .o_wr_addr      (o_wr_addr),
        .o_rd_en        (o_rd_en),
        .o_rd_line_sel  (o_rd_line_sel),
        .o_rd_addr      (o_rd_addr),
        .o_window_valid (o_window_valid),
        .o_busy         (o_busy),
        .o_frame_done   (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    int pix_cnt, win_cnt, done_cnt;
    int t12, t_rd, t_lastwin, t_done, t_rdylow, rdy_low, rd_sel0, n_addr, busy_after;
    int addr_seq [4];
    int snap16 [6];
    int snap17 [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_quiet(input string pfx);
        chk({pfx, "_ready"},     o_ready,        0);
        chk({pfx, "_wr_en"},     o_wr_en,        0);
        chk({pfx, "_wr_sel"},    o_wr_line_sel,  0);
        chk({pfx, "_wr_addr"},   o_wr_addr,      0);
        chk({pfx, "_rd_en"},     o_rd_en,        0);
        chk({pfx, "_rd_sel"},    o_rd_line_sel,  0);
        chk({pfx, "_rd_addr"},   o_rd_addr,      0);
        chk({pfx, "_win"},       o_window_valid, 0);
        chk({pfx, "_busy"},      o_busy,         0);
        chk({pfx, "_done"},      o_frame_done,   0);
    endtask

    // Cycle r counts from the first RUN cycle; samples are taken on the falling edge.
    task automatic run_frame(input int start_rel, input int drop_rel, input int reset_rel, input int max_cyc);
        pix_cnt = 0; win_cnt = 0; done_cnt = 0;
        t12 = -1; t_rd = -1; t_lastwin = -1; t_done = -1; t_rdylow = -1;
        rdy_low = 0; rd_sel0 = -1; n_addr = 0; busy_after = -1;
        i_start = 1'b1;
        i_pixel_valid = 1'b0;
        edge_step();
        for (int r = 0; r < max_cyc; r++) begin
            i_pixel_valid = (r != drop_rel);
            i_start       = (r == start_rel);
            i_reset       = (r == reset_rel);
            @(negedge i_clk);
            if (o_wr_en) begin
                pix_cnt++;
                if (pix_cnt == 12) t12 = r;
            end
            if (!o_ready && o_busy && pix_cnt < W * H) begin
                rdy_low++;
                if (t_rdylow < 0) t_rdylow = r;
            end
            if (o_rd_en) begin
                if (t_rd < 0) begin
                    t_rd = r;
                    rd_sel0 = int'(o_rd_line_sel);
                end
                if (n_addr < 4) begin
                    addr_seq[n_addr] = int'(o_rd_addr);
                    n_addr++;
                end
            end
            if (o_window_valid) begin
                win_cnt++;
                t_lastwin = r;
            end
            if (r == 16) begin
                snap16[0] = int'(o_wr_en);  snap16[1] = int'(o_wr_addr);
                snap16[2] = int'(o_rd_en);  snap16[3] = int'(o_rd_addr);
                snap16[4] = int'(o_wr_line_sel); snap16[5] = int'(o_rd_line_sel);
            end
            if (r == 17) begin
                snap17[0] = int'(o_wr_line_sel); snap17[1] = int'(o_rd_line_sel);
                snap17[2] = int'(o_ready);
            end
            if (t_done >= 0 && r == t_done + 1) begin
                busy_after = int'(o_busy);
                break;
            end
            if (o_frame_done) begin
                done_cnt++;
                t_done = r;
            end
            edge_step();
            if (r == reset_rel) break;
        end
        i_start = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_pixel_valid = 1'b1;
        repeat (3) edge_step();
        check_quiet("reset");

        i_start = 1'b1;
        edge_step();
        chk("reset_over_start_busy", o_busy, 0);
        i_reset = 1'b0;
        i_start = 1'b0;
        edge_step();
        chk("idle_ready", o_ready, 0);
        chk("idle_wr_en", o_wr_en, 0);

        // Continuous input: read window opens two cycles after the 12th pixel.
        run_frame(-1, -1, -1, 100);
        chk("f1_pixels",     pix_cnt,     24);
        chk("f1_windows",    win_cnt,     16);
        chk("f1_done_cnt",   done_cnt,    1);
        chk("f1_t12",        t12,         11);
        chk("f1_rd_rise",    t_rd,        13);
        chk("f1_rd_sel0",    rd_sel0,     0);
        for (int i = 0; i < 4; i++) chk($sformatf("f1_rd_addr%0d", i), addr_seq[i], i);
        chk("f1_rdy_low_at", t_rdylow,    16);
        chk("f1_rdy_low_n",  rdy_low,     2);
        chk("f1_rdy_back",   snap17[2],   1);
        chk("f1_last_win",   t_lastwin,   32);
        chk("f1_done_at",    t_done,      33);
        chk("f1_busy_after", busy_after,  0);

        // One-cycle input bubble aligns write-line and read-line completion at r=16.
        i_pixel_valid = 1'b0;
        edge_step();
        run_frame(-1, 15, -1, 100);
        chk("f2_both_wr_en",   snap16[0], 1);
        chk("f2_both_wr_addr", snap16[1], 3);
        chk("f2_both_rd_en",   snap16[2], 1);
        chk("f2_both_rd_addr", snap16[3], 3);
        chk("f2_both_wr_sel",  snap16[4], 3);
        chk("f2_both_rd_sel",  snap16[5], 0);
        chk("f2_next_wr_sel",  snap17[0], 0);
        chk("f2_next_rd_sel",  snap17[1], 1);
        chk("f2_next_ready",   snap17[2], 1);
        chk("f2_pixels",       pix_cnt,   24);
        chk("f2_windows",      win_cnt,   16);
        chk("f2_done_at",      t_done,    33);

        // Reset in the middle of the second read line.
        i_pixel_valid = 1'b0;
        edge_step();
        run_frame(-1, -1, 19, 100);
        chk("f3_win_before_rst", win_cnt, 5);
        check_quiet("midrst");
        i_start = 1'b1;
        edge_step();
        chk("midrst_start_busy", o_busy, 0);
        i_reset = 1'b0;
        i_start = 1'b0;
        i_pixel_valid = 1'b0;
        edge_step();
        chk("post_rst_busy", o_busy, 0);

        // Fresh frame; the start pulse at r=28 lands in DRAIN.
        run_frame(28, -1, -1, 100);
        chk("f4_pixels",     pix_cnt,    24);
        chk("f4_windows",    win_cnt,    16);
        chk("f4_done_cnt",   done_cnt,   1);
        chk("f4_done_at",    t_done,     33);
        chk("f4_busy_after", busy_after, 0);
        i_pixel_valid = 1'b0;
        repeat (3) edge_step();
        chk("f4_still_idle", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
